// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
package fetch_pkg;

  localparam logic [1:0] SIZE_NONE = 2'b00;
  localparam logic [1:0] SIZE_BYTE = 2'b01;
  localparam logic [1:0] SIZE_HALF = 2'b10;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP         = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer of {pc, inst} entries with synchronous clear and occupancy count.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  fetch_entry_t           push_entry,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count_q;
  logic           do_pop;

  assign do_pop = pop && !empty;
  assign empty  = (count_q == '0);
  assign full   = (count_q == CW'(DEPTH));
  assign count  = count_q;
  assign head   = mem[rd_ptr];

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !clear) assert (!(push && full && !do_pop));
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: issues word reads, buffers responses, hands them to decode.
// Optional halt-on-ebreak behaviour is enabled by defining FETCH_HALT_ON_EBREAK_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] bus_addr,
  output logic        bus_rw,
  output logic [1:0]  bus_size,
  input  logic [31:0] bus_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        halted
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OW = CW + 1;

`ifdef FETCH_HALT_ON_EBREAK_EN
  typedef enum logic [1:0] {ST_RESET, ST_RUN, ST_HALT} state_t;
`else
  typedef enum logic [1:0] {ST_RESET, ST_RUN} state_t;
`endif

  state_t        state;
  logic [31:0]   pc;
  logic [31:0]   last_addr;
  logic [31:0]   req_pc;
  logic          epoch;
  logic          req_epoch;
  logic          inflight;
  logic          issue;
  logic          capture;
  logic          pop;
  logic [OW-1:0] occ;
  fetch_entry_t  head;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;

  assign pop = !empty && inst_ready;
  // Space check counts the response already on the bus and credits a same-cycle pop.
  assign occ     = OW'(count) + OW'(inflight) - OW'(pop);
  assign issue   = (state == ST_RUN) && !redirect_valid && (occ < OW'(FIFO_DEPTH));
  assign capture = inflight && (req_epoch == epoch) && !redirect_valid && (state == ST_RUN);

  assign bus_size   = (issue || inflight) ? SIZE_WORD : SIZE_NONE;
  assign bus_addr   = issue ? pc : last_addr;
  assign bus_rw     = 1'b0;
  assign inst_valid = !empty;
  assign inst_data  = head.inst;
  assign inst_pc    = head.pc;

`ifdef FETCH_HALT_ON_EBREAK_EN
  logic halted_q;
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_RESET;
      pc        <= RESET_PC;
      last_addr <= RESET_PC;
      req_pc    <= RESET_PC;
      epoch     <= 1'b0;
      req_epoch <= 1'b0;
      inflight  <= 1'b0;
`ifdef FETCH_HALT_ON_EBREAK_EN
      halted_q  <= 1'b0;
`endif
    end else begin
      inflight <= issue;
      if (issue) begin
        pc        <= pc + 32'd4;
        last_addr <= pc;
        req_pc    <= pc;
        req_epoch <= epoch;
      end
      if (redirect_valid) begin
        epoch <= ~epoch;
        pc    <= {redirect_pc[31:2], 2'b00};
      end
      case (state)
        ST_RESET: state <= ST_RUN;
`ifdef FETCH_HALT_ON_EBREAK_EN
        ST_RUN: begin
          if (capture && (bus_data == INSN_EBREAK)) begin
            state    <= ST_HALT;
            halted_q <= 1'b1;
          end
        end
        ST_HALT: begin
          if (redirect_valid) begin
            state    <= ST_RUN;
            halted_q <= 1'b0;
          end
        end
`else
        ST_RUN: state <= ST_RUN;
`endif
        default: state <= ST_RESET;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (redirect_valid),
    .push      (capture),
    .push_entry('{pc: req_pc, inst: bus_data}),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit against a 1-cycle registered ROM model.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] bus_addr;
  logic        bus_rw;
  logic [1:0]  bus_size;
  logic [31:0] bus_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        halted;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus_addr      (bus_addr),
    .bus_rw        (bus_rw),
    .bus_size      (bus_size),
    .bus_data      (bus_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst_data     (inst_data),
    .inst_pc       (inst_pc),
    .halted        (halted)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a == 32'h0000_003C) ? INSN_EBREAK : (~a ^ 32'h5A00_0000);
  endfunction

  logic [31:0] rom_q = '0;
  always @(posedge clk) if (bus_size == SIZE_WORD) rom_q <= rom_word(bus_addr);
  assign bus_data = rom_q;

  int tests  = 0;
  int errors = 0;
  int gaps;
  fetch_entry_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_run(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = start + 32'(4 * i);
      exp_q.push_back('{pc: a, inst: rom_word(a)});
    end
  endtask

  task automatic drain(input string tag, input int budget, output int gap_cnt);
    int cyc;
    bit started;
    fetch_entry_t e;
    gap_cnt = 0;
    cyc = 0;
    started = 0;
    @(posedge clk);
    #1 inst_ready = 1'b1;
    while (exp_q.size() > 0 && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (inst_valid) begin
        started = 1;
        e = exp_q.pop_front();
        check({tag, "_pc"}, inst_pc, e.pc);
        check({tag, "_data"}, inst_data, e.inst);
      end else if (started) begin
        gap_cnt++;
      end
    end
    if (exp_q.size() > 0) begin
      check({tag, "_timeout"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(posedge clk);
    #1 inst_ready = 1'b0;
  endtask

  task automatic pulse_redirect(input logic [31:0] target);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0500;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_size", 32'(bus_size), 32'(SIZE_NONE));
    check("rst_addr", bus_addr, 32'h0);
    check("rst_rw", 32'(bus_rw), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    redirect_valid = 1'b0;
    rst_n          = 1'b1;
    @(negedge clk);
    check("first_req_size", 32'(bus_size), 32'(SIZE_WORD));
    check("first_req_addr", bus_addr, 32'h0);

    // Decode stalled: two words buffered, bus idle, head stable.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 4) begin
        check("stall_valid", 32'(inst_valid), 32'd1);
        check("stall_pc", inst_pc, 32'h0);
        check("stall_data", inst_data, rom_word(32'h0));
        check("stall_size", 32'(bus_size), 32'(SIZE_NONE));
      end
    end
    expect_run(32'h0, 12);
    drain("stream", 200, gaps);
    check("stream_gaps", 32'(gaps), 32'd0);

    // Redirect while the 0x100 response is in flight.
    pulse_redirect(32'h0000_0100);
    #1;
    check("rd1_size", 32'(bus_size), 32'(SIZE_WORD));
    check("rd1_addr", bus_addr, 32'h0000_0100);
    check("rd1_valid", 32'(inst_valid), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0033;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("rd2_valid", 32'(inst_valid), 32'd0);
    check("rd2_addr", bus_addr, 32'h0000_0030);
    check("rd2_size", 32'(bus_size), 32'(SIZE_WORD));
    expect_run(32'h0000_0030, 3);
    drain("redir", 50, gaps);

    // Address wrap past the top of memory.
    pulse_redirect(32'hFFFF_FFF8);
    expect_run(32'hFFFF_FFF8, 4);
    drain("wrap", 50, gaps);
    check("wrap_gaps", 32'(gaps), 32'd0);

    // Ebreak at 0x3C.
    pulse_redirect(32'h0000_0030);
`ifdef FETCH_HALT_ON_EBREAK_EN
    expect_run(32'h0000_0030, 4);
    drain("ebreak", 50, gaps);
    repeat (4) @(negedge clk);
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_valid", 32'(inst_valid), 32'd0);
    check("halt_size", 32'(bus_size), 32'(SIZE_NONE));
`else
    expect_run(32'h0000_0030, 6);
    drain("ebreak", 50, gaps);
    @(negedge clk);
    check("nohalt_flag", 32'(halted), 32'd0);
`endif

    // Reset mid-stream with a full buffer.
    pulse_redirect(32'h0000_0080);
    repeat (5) @(negedge clk);
    check("full_valid", 32'(inst_valid), 32'd1);
    check("full_pc", inst_pc, 32'h0000_0080);
    check("full_halted", 32'(halted), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(inst_valid), 32'd0);
    check("mid_rst_size", 32'(bus_size), 32'(SIZE_NONE));
    check("mid_rst_addr", bus_addr, 32'h0);
    check("mid_rst_halted", 32'(halted), 32'd0);
    rst_n = 1'b1;
    expect_run(32'h0, 3);
    drain("restart", 50, gaps);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
